// File: rtl/uart_pkg.sv
// Shared UART constants, sync byte default and frame assembler state encoding.
// Imported by the UART receiver side blocks and the frame assembler.
package uart_pkg;

  localparam int unsigned CLK_HZ      = 60_000_000;
  localparam int unsigned BAUD        = 9600;
  localparam int unsigned BIT_CYCLES  = CLK_HZ / BAUD;
  localparam int unsigned BYTE_CYCLES = BIT_CYCLES * 10;
  localparam int unsigned TIMEOUT_DEF = BYTE_CYCLES * 4;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_COLLECT,
    ST_CHECK,
    ST_HOLD
  } fa_state_e;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte watchdog: counts enabled cycles, expired_o pulses on the last one.
// Ports: clk, rst_n (async low), clear_i, enable_i, expired_o.
module uart_byte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // A clear in the same cycle (byte arrived) beats expiry.
  assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

  // Restart on expiry so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expired_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_assembler.sv
// Hunts for SYNC, collects NUM_BYTES payload, checks XOR sum, presents frame.
// Ports: clk, reset (async low), rx_byte/rx_valid in, frame_* handshake, status pulses.
module uart_frame_assembler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = 8,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  output logic [8*NUM_BYTES-1:0] frame_data,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic                   busy,
  output logic                   chk_err,
  output logic                   timeout,
  output logic                   overrun
);

  localparam int unsigned IW = $clog2(NUM_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

  fa_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0] chk_q, chk_d;
  logic [8*NUM_BYTES-1:0] lanes_q, lanes_d;
  logic [8*NUM_BYTES-1:0] data_q, data_d;
  logic busy_q, valid_q;
  logic chk_err_q, chk_err_d;
  logic tmo_q, tmo_d;
  logic ovr_q, ovr_d;
  logic in_frame;
  logic tmr_exp;

  assign in_frame = (state_q == ST_COLLECT) || (state_q == ST_CHECK);

  uart_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .clear_i  (rx_valid || !in_frame),
    .enable_i (in_frame),
    .expired_o(tmr_exp)
  );

  // Payload lands in lanes_q; data_q only copies it once the checksum
  // matches, so a bad frame never disturbs the presented word.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    lanes_d   = lanes_q;
    data_d    = data_q;
    chk_err_d = 1'b0;
    tmo_d     = 1'b0;
    ovr_d     = 1'b0;
    unique case (state_q)
      ST_HUNT: begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_d = ST_COLLECT;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
      ST_COLLECT: begin
        if (rx_valid) begin
          lanes_d[idx_q*8 +: 8] = rx_byte;
          chk_d = chk_q ^ rx_byte;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_CHECK;
          end
        end else if (tmr_exp) begin
          tmo_d   = 1'b1;
          state_d = ST_HUNT;
        end
      end
      ST_CHECK: begin
        if (rx_valid) begin
          if (rx_byte == chk_q) begin
            state_d = ST_HOLD;
            data_d  = lanes_q;
          end else begin
            chk_err_d = 1'b1;
            state_d   = ST_HUNT;
          end
        end else if (tmr_exp) begin
          tmo_d   = 1'b1;
          state_d = ST_HUNT;
        end
      end
      ST_HOLD: begin
        if (rx_valid) begin
          ovr_d = 1'b1;
        end
        if (frame_ready) begin
          state_d = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_HUNT;
      idx_q     <= '0;
      chk_q     <= '0;
      lanes_q   <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      chk_err_q <= 1'b0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      lanes_q   <= lanes_d;
      data_q    <= data_d;
      busy_q    <= (state_d != ST_HUNT);
      valid_q   <= (state_d == ST_HOLD);
      chk_err_q <= chk_err_d;
      tmo_q     <= tmo_d;
      ovr_q     <= ovr_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign busy        = busy_q;
  assign chk_err     = chk_err_q;
  assign timeout     = tmo_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Self-checking bench for uart_frame_assembler.
// Directed scenarios plus randomized frames against a byte-level model.
module tb_uart_frame_assembler;

  localparam int NB = 8;
  localparam int TO = 40;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] rx_byte;
  logic rx_valid;
  logic [8*NB-1:0] frame_data;
  logic frame_valid;
  logic frame_ready;
  logic busy;
  logic chk_err;
  logic timeout;
  logic overrun;

  int n_cmp = 0;
  int n_err = 0;
  int n_chk = 0;
  int n_to  = 0;
  int n_ovr = 0;

  logic [7:0] pl [NB];
  logic [8*NB-1:0] last_frame;

  always #5 clk = ~clk;

  uart_frame_assembler #(
    .NUM_BYTES(NB),
    .SYNC_BYTE(SYNC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .busy       (busy),
    .chk_err    (chk_err),
    .timeout    (timeout),
    .overrun    (overrun)
  );

  // Pulses last one full cycle, so each is seen at exactly one negedge.
  always @(negedge clk) begin
    if (reset) begin
      if (chk_err) n_chk <= n_chk + 1;
      if (timeout) n_to  <= n_to + 1;
      if (overrun) n_ovr <= n_ovr + 1;
    end
  end

  function automatic logic [8*NB-1:0] pack();
    logic [8*NB-1:0] w;
    w = '0;
    for (int k = 0; k < NB; k++) w[8*k +: 8] = pl[k];
    return w;
  endfunction

  function automatic logic [7:0] xsum();
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < NB; k++) s = s ^ pl[k];
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic send_payload(input int maxgap);
    send_byte(SYNC);
    for (int k = 0; k < NB; k++) begin
      if (maxgap > 0) tick($urandom_range(0, maxgap));
      send_byte(pl[k]);
    end
  endtask

  task automatic rand_payload();
    for (int k = 0; k < NB; k++) pl[k] = 8'($urandom);
  endtask

  task automatic check_frame(input string nm, input logic [8*NB-1:0] exp);
    n_cmp++;
    if (frame_valid !== 1'b1 || frame_data !== exp) begin
      n_err++;
      $display("FAIL %s: valid=%b data=%h, required valid=1 data=%h",
               nm, frame_valid, frame_data, exp);
    end
  endtask

  task automatic handshake(input string nm);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    n_cmp++;
    if (frame_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s: after handshake valid=%b busy=%b, required 0/0",
               nm, frame_valid, busy);
    end
  endtask

  task automatic check_counts(input string nm,
                              input int c0, input int t0, input int o0,
                              input int dc, input int dt, input int dov);
    settle();
    n_cmp++;
    if (n_chk - c0 != dc || n_to - t0 != dt || n_ovr - o0 != dov) begin
      n_err++;
      $display("FAIL %s pulses: chk/to/ovr=%0d/%0d/%0d, required %0d/%0d/%0d",
               nm, n_chk - c0, n_to - t0, n_ovr - o0, dc, dt, dov);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    frame_ready = 1'b0;
    tick(3);
    n_cmp++;
    if ({frame_valid, busy, chk_err, timeout, overrun} !== 5'b0 ||
        frame_data !== '0) begin
      n_err++;
      $display("FAIL reset: outs=%b data=%h, required 0",
               {frame_valid, busy, chk_err, timeout, overrun}, frame_data);
    end
    @(negedge clk);
    reset = 1'b1;
    tick(2);
    last_frame = '0;
  endtask

  task automatic test_good_frame();
    int c0, t0, o0;
    c0 = n_chk; t0 = n_to; o0 = n_ovr;
    for (int k = 0; k < NB; k++) pl[k] = 8'(k + 1);
    send_payload(0);
    n_cmp++;
    if (frame_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL good_pre: valid=%b busy=%b, required 0/1",
               frame_valid, busy);
    end
    send_byte(8'h08);
    check_frame("good_frame", 64'h0807060504030201);
    last_frame = 64'h0807060504030201;
    handshake("good_frame");
    check_counts("good_frame", c0, t0, o0, 0, 0, 0);
  endtask

  task automatic test_bad_checksum();
    int c0, t0, o0;
    c0 = n_chk; t0 = n_to; o0 = n_ovr;
    for (int k = 0; k < NB; k++) pl[k] = 8'(k + 1);
    send_payload(0);
    send_byte(8'h09);
    n_cmp++;
    if (chk_err !== 1'b1 || frame_valid !== 1'b0 || busy !== 1'b0 ||
        frame_data !== last_frame) begin
      n_err++;
      $display("FAIL bad_chk: err=%b valid=%b busy=%b data=%h, required 1/0/0 %h",
               chk_err, frame_valid, busy, frame_data, last_frame);
    end
    tick(1);
    n_cmp++;
    if (chk_err !== 1'b0) begin
      n_err++;
      $display("FAIL bad_chk_width: chk_err=%b, required 0", chk_err);
    end
    check_counts("bad_chk", c0, t0, o0, 1, 0, 0);
  endtask

  task automatic test_leading_junk();
    int c0, t0, o0;
    c0 = n_chk; t0 = n_to; o0 = n_ovr;
    send_byte(8'h33);
    send_byte(8'h5A);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL junk_busy: busy=%b, required 0", busy);
    end
    rand_payload();
    send_payload(2);
    send_byte(xsum());
    check_frame("junk_frame", pack());
    last_frame = pack();
    handshake("junk_frame");
    check_counts("junk", c0, t0, o0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    int c0, t0, o0;
    c0 = n_chk; t0 = n_to; o0 = n_ovr;
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h02);
    for (int i = 1; i < TO; i++) begin
      tick(1);
      n_cmp++;
      if (timeout !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL timeout_early: idle=%0d to=%b busy=%b, required 0/1",
                 i, timeout, busy);
      end
    end
    tick(1);
    n_cmp++;
    if (timeout !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_fire: to=%b busy=%b, required 1/0", timeout, busy);
    end
    check_counts("timeout", c0, t0, o0, 0, 1, 0);
    // A byte landing on the last allowed cycle is consumed, not timed out.
    c0 = n_chk; t0 = n_to; o0 = n_ovr;
    rand_payload();
    send_byte(SYNC);
    for (int k = 0; k < NB; k++) begin
      if (k == 3) tick(TO - 1);
      send_byte(pl[k]);
    end
    tick(TO - 1);
    send_byte(xsum());
    check_frame("timeout_edge", pack());
    last_frame = pack();
    handshake("timeout_edge");
    check_counts("timeout_edge", c0, t0, o0, 0, 0, 0);
  endtask

  task automatic test_overrun();
    int c0, t0, o0;
    c0 = n_chk; t0 = n_to; o0 = n_ovr;
    rand_payload();
    send_payload(1);
    send_byte(xsum());
    last_frame = pack();
    tick(3);
    send_byte(8'h7E);
    n_cmp++;
    if (overrun !== 1'b1 || frame_valid !== 1'b1 ||
        frame_data !== last_frame) begin
      n_err++;
      $display("FAIL overrun: ovr=%b valid=%b data=%h, required 1/1 %h",
               overrun, frame_valid, frame_data, last_frame);
    end
    // Handshake with a byte in the same cycle: dropped, frame released.
    frame_ready = 1'b1;
    send_byte(SYNC);
    frame_ready = 1'b0;
    n_cmp++;
    if (overrun !== 1'b1 || frame_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_hs: ovr=%b valid=%b busy=%b, required 1/0/0",
               overrun, frame_valid, busy);
    end
    rand_payload();
    send_payload(0);
    send_byte(xsum());
    check_frame("after_overrun", pack());
    last_frame = pack();
    handshake("after_overrun");
    check_counts("overrun", c0, t0, o0, 0, 0, 2);
  endtask

  task automatic test_reset_mid_frame();
    send_byte(SYNC);
    for (int k = 0; k < 4; k++) send_byte(8'($urandom));
    #2;
    reset = 1'b0;
    #2;
    n_cmp++;
    if ({frame_valid, busy, chk_err, timeout, overrun} !== 5'b0 ||
        frame_data !== '0) begin
      n_err++;
      $display("FAIL reset_mid: outs=%b data=%h, required 0",
               {frame_valid, busy, chk_err, timeout, overrun}, frame_data);
    end
    tick(2);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    last_frame = '0;
    rand_payload();
    send_payload(1);
    send_byte(xsum());
    check_frame("reset_mid_frame", pack());
    last_frame = pack();
    handshake("reset_mid_frame");
  endtask

  task automatic test_random();
    int c0, t0, o0, ec, eo;
    logic good;
    logic [7:0] ck;
    c0 = n_chk; t0 = n_to; o0 = n_ovr;
    ec = 0; eo = 0;
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] j;
        j = 8'($urandom);
        if (j == SYNC) j = 8'h00;
        send_byte(j);
      end
      rand_payload();
      good = ($urandom_range(0, 2) != 0);
      ck = xsum();
      if (!good) ck = ck ^ 8'($urandom_range(1, 255));
      send_payload(3);
      send_byte(ck);
      if (good) begin
        check_frame("rand_frame", pack());
        last_frame = pack();
        tick($urandom_range(0, 4));
        if ($urandom_range(0, 3) == 0) begin
          send_byte(8'($urandom));
          eo++;
        end
        handshake("rand_frame");
      end else begin
        ec++;
        n_cmp++;
        if (chk_err !== 1'b1 || frame_valid !== 1'b0 ||
            frame_data !== last_frame) begin
          n_err++;
          $display("FAIL rand_bad: err=%b valid=%b data=%h, required 1/0 %h",
                   chk_err, frame_valid, frame_data, last_frame);
        end
      end
    end
    check_counts("random", c0, t0, o0, ec, 0, eo);
  endtask

  task automatic test_back_to_back();
    int c0, t0, o0;
    c0 = n_chk; t0 = n_to; o0 = n_ovr;
    frame_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rand_payload();
      send_payload(0);
      send_byte(xsum());
      check_frame("b2b_frame", pack());
      last_frame = pack();
      tick(1);
      n_cmp++;
      if (frame_valid !== 1'b0 || frame_data !== last_frame) begin
        n_err++;
        $display("FAIL b2b_release: valid=%b data=%h, required 0 %h",
                 frame_valid, frame_data, last_frame);
      end
    end
    frame_ready = 1'b0;
    check_counts("b2b", c0, t0, o0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_leading_junk();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
